// File: rtl/qr_recompose4.sv
// qr_recompose4: sequential 4x4 fp32 A = Q*R with upper-triangular R.
// One multiply-accumulate per cycle, 40 terms, truncating fp arithmetic.
module qr_recompose4 #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [0:N-1][0:N-1][W-1:0]    Q_matrix,
    input  logic [0:N-1][0:N-1][W-1:0]    R_matrix,
    output logic [0:N-1][0:N-1][W-1:0]    A_matrix,
    output logic                          busy,
    output logic                          done
);

    if (N != 4 || W != 32) begin : g_bad_param
        $error("qr_recompose4 supports only N=4, W=32");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [0:3][0:3][31:0]   r_q;
    logic [0:3][0:3][31:0]   r_r;
    logic [31:0]             r_acc;
    logic [1:0]              r_i;
    logic [1:0]              r_j;
    logic [1:0]              r_k;
    logic [31:0]             w_prod;
    logic [31:0]             w_sum;
    logic                    w_last;
    logic                    w_col_end;

    function automatic logic [31:0] fp_mul(input logic [31:0] a,
                                           input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [9:0]  eo;
        logic [22:0] m;
        logic [31:0] res;
        p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e   = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'd0, p[47]};
        eo  = e - 10'd127;
        m   = p[47] ? p[46:24] : p[45:23];
        res = 32'h0;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
            res = 32'h0;
        else if (e >= 10'd382)
            res = {a[31] ^ b[31], 8'hFF, 23'd0};
        else if (e > 10'd127)
            res = {a[31] ^ b[31], eo[7:0], m};
        return res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [7:0]  d;
        logic [23:0] mb;
        logic [23:0] ms;
        logic [24:0] sum;
        logic [23:0] diff;
        logic [23:0] norm;
        logic [4:0]  lz;
        logic        found;
        logic [9:0]  e;
        logic [31:0] res;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d     = big[30:23] - sml[30:23];
        mb    = {1'b1, big[22:0]};
        ms    = (d >= 8'd25) ? 24'd0 : ({1'b1, sml[22:0]} >> d);
        sum   = {1'b0, mb} + {1'b0, ms};
        diff  = mb - ms;
        lz    = 5'd0;
        found = 1'b0;
        for (int n = 23; n >= 0; n--) begin
            if (!found) begin
                if (diff[n]) found = 1'b1;
                else lz = lz + 5'd1;
            end
        end
        norm = diff << lz;
        res  = 32'h0;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            res = 32'h0;
        end else if (a[30:23] == 8'd0) begin
            res = b;
        end else if (b[30:23] == 8'd0) begin
            res = a;
        end else if (big[31] == sml[31]) begin
            e = {2'b0, big[30:23]} + {9'd0, sum[24]};
            if (e >= 10'd255)
                res = {big[31], 8'hFF, 23'd0};
            else
                res = {big[31], e[7:0],
                       sum[24] ? sum[23:1] : sum[22:0]};
        end else if (diff != 24'd0) begin
            // Truncating subtract: renormalise by the leading-zero count.
            e = {2'b0, big[30:23]} - {5'd0, lz};
            if ({2'b0, big[30:23]} > {5'd0, lz})
                res = {big[31], e[7:0], norm[22:0]};
        end
        return res;
    endfunction

    assign w_prod    = fp_mul(r_q[r_i][r_k], r_r[r_k][r_j]);
    assign w_sum     = fp_add(r_acc, w_prod);
    assign w_col_end = (r_k == r_j);
    assign w_last    = (r_i == 2'd3) && (r_j == 2'd3) && (r_k == 2'd3);

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_r      <= '0;
            r_acc    <= 32'h0;
            r_i      <= 2'd0;
            r_j      <= 2'd0;
            r_k      <= 2'd0;
            A_matrix <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                for (int a = 0; a < 4; a++) begin
                    for (int b = 0; b < 4; b++) begin
                        r_q[a][b] <= Q_matrix[a][b];
                        r_r[a][b] <= (a <= b) ? R_matrix[a][b] : 32'h0;
                    end
                end
                r_acc <= 32'h0;
                r_i   <= 2'd0;
                r_j   <= 2'd0;
                r_k   <= 2'd0;
            end else if (r_state == S_RUN) begin
                if (w_col_end) begin
                    A_matrix[r_i][r_j] <= w_sum;
                    r_acc <= 32'h0;
                    r_k   <= 2'd0;
                    r_j   <= r_j + 2'd1;
                    if (r_j == 2'd3) r_i <= r_i + 2'd1;
                end else begin
                    r_acc <= w_sum;
                    r_k   <= r_k + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qr_recompose4.sv
// tb_qr_recompose4: vector table of Q/R/A triples checked through a
// scoreboard queue, plus ignored-start and mid-run reset sequences.
module tb_qr_recompose4;

    typedef logic [0:3][0:3][31:0] mat_t;
    typedef struct packed {
        mat_t q;
        mat_t r;
        mat_t a;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    mat_t q_in;
    mat_t r_in;
    mat_t a_out;
    logic busy;
    logic done;

    int   n_tests = 0;
    int   n_fail  = 0;
    mat_t sb_q[$];
    mat_t prev_a;
    vec_t vecs[8];
    string names[8];

    always #5 clk = ~clk;

    qr_recompose4 #(.N(4), .W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .Q_matrix (q_in),
        .R_matrix (r_in),
        .A_matrix (a_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkmat(input string nm, input mat_t act, input mat_t exp);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk32($sformatf("%s A[%0d][%0d]", nm, i, j),
                      act[i][j], exp[i][j]);
    endtask

    function automatic mat_t ident(input logic [31:0] d);
        mat_t m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = d;
        return m;
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                q_in[i][j] = $urandom();
                r_in[i][j] = $urandom();
            end
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit poke);
        int   cyc;
        bit   got;
        mat_t exp;
        @(negedge clk);
        q_in  = v.q;
        r_in  = v.r;
        start = 1'b1;
        @(posedge clk);
        sb_q.push_back(v.a);
        #1;
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk32({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
        chkmat({nm, " hold_on_start"}, a_out, prev_a);
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(posedge clk);
            cyc++;
            if (poke && cyc == 10) begin
                #1 start = 1'b1;
            end else if (poke && cyc == 11) begin
                #1 start = 1'b0;
            end
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk32({nm, " done_latency"}, got ? cyc : 32'hFFFF_FFFF, 32'd40);
        exp = sb_q.pop_front();
        if (got) begin
            chk32({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
            chkmat(nm, a_out, exp);
        end
        @(negedge clk);
        chk32({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
        prev_a = exp;
    endtask

    initial begin
        logic [31:0] row0 [4];
        mat_t m;
        int   seen;

        row0 = '{32'h3FC00000, 32'hBE99999A, 32'h40490FDB, 32'hC1200000};

        names[0] = "identQ";
        vecs[0].q = ident(32'h3F800000);
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = (i <= j) ? row0[j] : 32'h12345678;
        vecs[0].r = m;
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = i; j < 4; j++) m[i][j] = row0[j];
        vecs[0].a = m;

        names[1] = "ones";
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[i][j] = 32'h3F800000;
        vecs[1].q = m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = (i <= j) ? 32'h3F800000 : 32'hDEADBEEF;
        vecs[1].r = m;
        for (int i = 0; i < 4; i++) begin
            m[i][0] = 32'h3F800000;
            m[i][1] = 32'h40000000;
            m[i][2] = 32'h40400000;
            m[i][3] = 32'h40800000;
        end
        vecs[1].a = m;

        names[2] = "scaled_diag";
        vecs[2].q = ident(32'h40000000);
        vecs[2].r = ident(32'h3F000000);
        vecs[2].a = ident(32'h3F800000);

        names[3] = "cancel";
        m = '0;
        m[0][0] = 32'h3F800000;
        m[0][1] = 32'hBF800000;
        vecs[3].q = m;
        m = '0;
        m[0][1] = 32'h3F800000;
        m[1][1] = 32'h3F800000;
        vecs[3].r = m;
        vecs[3].a = '0;

        names[4] = "sat_flush";
        m = '0;
        m[0][0] = 32'h7F000000;
        m[1][1] = 32'h00800000;
        vecs[4].q = m;
        vecs[4].r = m;
        m = '0;
        m[0][0] = 32'h7F800000;
        vecs[4].a = m;

        names[5] = "one_half";
        m = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m[i][j] = 32'h3FC00000;
        vecs[5].q = m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = (i <= j) ? 32'h3FC00000 : 32'h0;
        vecs[5].r = m;
        for (int i = 0; i < 4; i++) begin
            m[i][0] = 32'h40100000;
            m[i][1] = 32'h40900000;
            m[i][2] = 32'h40D80000;
            m[i][3] = 32'h41100000;
        end
        vecs[5].a = m;

        names[6] = "sub_norm";
        m = '0;
        m[1][1] = 32'h3F800000;
        m[1][2] = 32'hBF700000;
        vecs[6].q = m;
        m = '0;
        m[1][2] = 32'h3F800000;
        m[2][2] = 32'h3F800000;
        vecs[6].r = m;
        m = '0;
        m[1][2] = 32'h3D800000;
        vecs[6].a = m;

        names[7] = "big_shift";
        m = '0;
        m[2][0] = 32'h3F800000;
        m[2][1] = 32'h30800000;
        vecs[7].q = m;
        m = '0;
        m[0][1] = 32'h3F800000;
        m[1][1] = 32'h3F800000;
        vecs[7].r = m;
        m = '0;
        m[2][1] = 32'h3F800000;
        vecs[7].a = m;

        prev_a = '0;
        reset  = 1'b0;
        start  = 1'b0;
        q_in   = '0;
        r_in   = '0;
        #12;
        chk32("reset busy", {31'd0, busy}, 32'd0);
        chk32("reset done", {31'd0, done}, 32'd0);
        chkmat("reset", a_out, '0);
        @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 8; t++) run_vec(vecs[t], names[t], 1'b0);

        run_vec(vecs[1], "restart_ignored", 1'b1);

        @(negedge clk);
        q_in  = vecs[5].q;
        r_in  = vecs[5].r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk32("abort busy", {31'd0, busy}, 32'd0);
        chk32("abort done", {31'd0, done}, 32'd0);
        chkmat("abort", a_out, '0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk32("abort no_done", seen, 32'd0);
        prev_a = '0;

        run_vec(vecs[2], "after_abort", 1'b0);
        chk32("scoreboard empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
